fp_operand_unpacker: RTL

//  Decode side of the fpbus datapath: inverse of the pack stage. Accepts raw IEEE-754 single

---
 rtl/fp_pkg.sv | 56 +++++
 rtl/fp_classify.sv | 47 ++++
 rtl/fp_operand_unpacker.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared types for the fpbus datapath.
// Field widths, operand classes and decoded bundles.
package fp_pkg;

    localparam int FP_EXP_W  = 8;
    localparam int FP_FRAC_W = 23;
    localparam logic [31:0] FP_QNAN = 32'h7FC00000;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        SUB  = 3'd1,
        NORM = 3'd2,
        INF  = 3'd3,
        QNAN = 3'd4,
        SNAN = 3'd5
    } fp_class_e;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_FRAC_W:0]   mant;
        fp_class_e            cls;
    } fp_unpacked_t;

    typedef struct packed {
        logic                 sign_a;
        logic                 sign_b;
        logic [FP_EXP_W-1:0]  exp_a;
        logic [FP_EXP_W-1:0]  exp_b;
        logic [FP_FRAC_W:0]   mant_a;
        logic [FP_FRAC_W:0]   mant_b;
        fp_class_e            cls_a;
        fp_class_e            cls_b;
        logic [FP_EXP_W-1:0]  exp_diff;
        logic                 swapped;
        logic                 special_valid;
        logic [31:0]          special_result;
    } fp_out_t;

    // Magnitude key: raw exponent field then fraction.
    // Subnormals carry effective exponent 1 but raw 0.
    function automatic logic [30:0] fp_mag_key(
        input fp_unpacked_t u
    );
        logic [FP_EXP_W-1:0] e;
        e = (u.cls == SUB) ? 8'h00 : u.exp;
        return {e, u.mant[FP_FRAC_W-1:0]};
    endfunction

    function automatic logic fp_is_nan(
        input fp_unpacked_t u
    );
        return (u.cls == QNAN) || (u.cls == SNAN);
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Field split and classification of one
// raw IEEE-754 single operand.
module fp_classify
    import fp_pkg::*;
(
    input  logic [31:0]  raw,
    input  logic         ftz,
    output fp_unpacked_t unp
);

    logic [FP_EXP_W-1:0]  e;
    logic [FP_FRAC_W-1:0] f;

    assign e = raw[30:23];
    assign f = raw[22:0];

    // Decode exponent/fraction into effective fields and class
    always_comb begin
        unp      = '0;
        unp.sign = raw[31];
        if (e == 8'h00) begin
            if ((f == '0) || ftz) begin
                unp.cls  = ZERO;
                unp.exp  = 8'h00;
                unp.mant = '0;
            end else begin
                unp.cls  = SUB;
                unp.exp  = 8'h01;
                unp.mant = {1'b0, f};
            end
        end else if (e == 8'hFF) begin
            unp.exp  = 8'hFF;
            unp.mant = {1'b1, f};
            if (f == '0)
                unp.cls = INF;
            else if (f[22])
                unp.cls = QNAN;
            else
                unp.cls = SNAN;
        end else begin
            unp.cls  = NORM;
            unp.exp  = e;
            unp.mant = {1'b1, f};
        end
    end

endmodule

// File: rtl/fp_operand_unpacker.sv
// Operand decode stage: classify, order by magnitude,
// flag special results, 2-entry skid output buffer.
module fp_operand_unpacker
    import fp_pkg::*;
#(
    parameter bit FTZ     = 1'b0,
    parameter bit SWAP_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        signA,
    output logic        signB,
    output logic [7:0]  exponentA,
    output logic [7:0]  exponentB,
    output logic [23:0] mantissaA,
    output logic [23:0] mantissaB,
    output logic [2:0]  classA,
    output logic [2:0]  classB,
    output logic [7:0]  expDiff,
    output logic        swapped,
    output logic        specialValid,
    output logic [31:0] specialResult
);

    fp_unpacked_t ua;
    fp_unpacked_t ub;
    fp_unpacked_t hi;
    fp_unpacked_t lo;
    fp_out_t      dec;
    logic         swap;

    fp_out_t main_q, main_d;
    fp_out_t skid_q, skid_d;
    logic    main_v_q, main_v_d;
    logic    skid_v_q, skid_v_d;
    logic    in_ready_q, in_ready_d;
    logic    in_fire;
    logic    out_fire;

    fp_classify u_cls_a (
        .raw (A),
        .ftz (FTZ),
        .unp (ua)
    );

    fp_classify u_cls_b (
        .raw (B),
        .ftz (FTZ),
        .unp (ub)
    );

    // Order the pair and resolve special-case results
    always_comb begin
        swap = SWAP_EN && (fp_mag_key(ub) > fp_mag_key(ua));
        hi   = swap ? ub : ua;
        lo   = swap ? ua : ub;

        dec          = '0;
        dec.sign_a   = hi.sign;
        dec.sign_b   = lo.sign;
        dec.exp_a    = hi.exp;
        dec.exp_b    = lo.exp;
        dec.mant_a   = hi.mant;
        dec.mant_b   = lo.mant;
        dec.cls_a    = hi.cls;
        dec.cls_b    = lo.cls;
        dec.exp_diff = hi.exp - lo.exp;
        dec.swapped  = swap;

        if (fp_is_nan(ua) || fp_is_nan(ub)) begin
            dec.special_valid  = 1'b1;
            dec.special_result = FP_QNAN;
        end else if ((ua.cls == INF) && (ub.cls == INF)) begin
            dec.special_valid  = 1'b1;
            dec.special_result = (ua.sign != ub.sign) ? FP_QNAN
                               : {ua.sign, 8'hFF, 23'h0};
        end else if (ua.cls == INF) begin
            dec.special_valid  = 1'b1;
            dec.special_result = {ua.sign, 8'hFF, 23'h0};
        end else if (ub.cls == INF) begin
            dec.special_valid  = 1'b1;
            dec.special_result = {ub.sign, 8'hFF, 23'h0};
        end else if ((ua.cls == ZERO) && (ub.cls == ZERO)) begin
            dec.special_valid  = 1'b1;
            dec.special_result = {ua.sign & ub.sign, 31'h0};
        end
    end

    assign in_fire  = in_valid && in_ready_q;
    assign out_fire = main_v_q && out_ready;

    // Main/skid next state; skid drains into main first
    always_comb begin
        main_d   = main_q;
        skid_d   = skid_q;
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        if (out_fire) begin
            if (skid_v_q) begin
                main_d   = skid_q;
                main_v_d = 1'b1;
                skid_v_d = 1'b0;
                if (in_fire) begin
                    skid_d   = dec;
                    skid_v_d = 1'b1;
                end
            end else begin
                main_v_d = in_fire;
                if (in_fire)
                    main_d = dec;
            end
        end else if (in_fire) begin
            if (!main_v_q) begin
                main_d   = dec;
                main_v_d = 1'b1;
            end else begin
                skid_d   = dec;
                skid_v_d = 1'b1;
            end
        end
        in_ready_d = !skid_v_d;
    end

    // State registers; in_ready stays low through reset
    always_ff @(posedge clk) begin
        if (reset) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_v_q   <= 1'b0;
            skid_v_q   <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_v_q   <= main_v_d;
            skid_v_q   <= skid_v_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = main_v_q;
    assign signA         = main_q.sign_a;
    assign signB         = main_q.sign_b;
    assign exponentA     = main_q.exp_a;
    assign exponentB     = main_q.exp_b;
    assign mantissaA     = main_q.mant_a;
    assign mantissaB     = main_q.mant_b;
    assign classA        = main_q.cls_a;
    assign classB        = main_q.cls_b;
    assign expDiff       = main_q.exp_diff;
    assign swapped       = main_q.swapped;
    assign specialValid  = main_q.special_valid;
    assign specialResult = main_q.special_result;

endmodule
